// File: rtl/aww_pipe_fifo.sv
// aww_pipe_fifo: elastic pipeline register between two stages.
// DEPTH-entry in-order circular buffer with valid/ready handshake, synchronous
// flush, and a BUBBLE (NOP) payload driven whenever the buffer is empty.
// All outputs are decoded from registered state; no input reaches an output
// combinationally.
module aww_pipe_fifo #(
  parameter int unsigned       WIDTH  = 32,
  parameter int unsigned       DEPTH  = 2,
  parameter logic [WIDTH-1:0]  BUBBLE = '0,
  localparam int unsigned      CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic [15:0]      drop_cnt
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];

  logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
  logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [15:0]      drop_q, drop_d;
  logic [16:0]      dropSum;
  logic             push, pop;

  // Explicit wrap so non-power-of-two depths index correctly.
  function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Status and handshake outputs, all from registered count.
  always_comb begin
    empty     = (count_q == '0);
    full      = (count_q == CNT_W'(DEPTH));
    in_ready  = ~full;
    out_valid = ~empty;
    out_data  = empty ? BUBBLE : mem[rdPtr_q];
    count     = count_q;
    drop_cnt  = drop_q;
    // in_ready deliberately ignores out_ready: a full buffer never takes a push.
    push      = in_valid & ~full;
    pop       = ~empty & out_ready;
  end

  // Next-state: flush overrides any concurrent push/pop.
  always_comb begin
    rdPtr_d = rdPtr_q;
    wrPtr_d = wrPtr_q;
    count_d = count_q;
    drop_d  = drop_q;
    dropSum = {1'b0, drop_q} + 17'(count_q);
    if (flush) begin
      rdPtr_d = '0;
      wrPtr_d = '0;
      count_d = '0;
      drop_d  = dropSum[16] ? 16'hFFFF : dropSum[15:0];
    end else begin
      if (push) wrPtr_d = nextPtr(wrPtr_q);
      if (pop)  rdPtr_d = nextPtr(rdPtr_q);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state register with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rdPtr_q <= '0;
      wrPtr_q <= '0;
      count_q <= '0;
      drop_q  <= '0;
    end else begin
      rdPtr_q <= rdPtr_d;
      wrPtr_q <= wrPtr_d;
      count_q <= count_d;
      drop_q  <= drop_d;
    end
  end

  // Payload storage; not reset, masked to BUBBLE at the output while empty.
  always_ff @(posedge CLK) begin
    if (!RST && !flush && push) begin
      mem[wrPtr_q] <= in_data;
    end
  end

endmodule
